// File: rtl/line_buff_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module   : line_buff_ctrl_if                                               |
// | Brief    : Pixel-in, line-buffer and column-out bus for line_buff_ctrl.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface line_buff_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              in_valid;
    logic              in_sof;
    logic [7:0]        in_data;

    logic [ADDR_W-1:0] lb_addr;
    logic [2:0]        lb_we;
    logic [7:0]        lb_wdata;
    logic [7:0]        lb_rdata0;
    logic [7:0]        lb_rdata1;
    logic [7:0]        lb_rdata2;

    logic              out_valid;
    logic [7:0]        out_top;
    logic [7:0]        out_mid;
    logic [7:0]        out_bot;
    logic [ADDR_W-1:0] out_x;
    logic [10:0]       out_y;
    logic              frame_done;

    // Controller view
    modport master (
        input  in_valid, in_sof, in_data,
        input  lb_rdata0, lb_rdata1, lb_rdata2,
        output lb_addr, lb_we, lb_wdata,
        output out_valid, out_top, out_mid, out_bot, out_x, out_y, frame_done
    );

    // Environment view: pixel source, line buffers and filter stage
    modport slave (
        output in_valid, in_sof, in_data,
        output lb_rdata0, lb_rdata1, lb_rdata2,
        input  lb_addr, lb_we, lb_wdata,
        input  out_valid, out_top, out_mid, out_bot, out_x, out_y, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/line_buff_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : line_buff_ctrl                                                  |
// | Brief    : Three-line-buffer ring sequencer producing 3-pixel columns.     |
// |            Option macro: LINE_BUFF_CTRL_BORDER_REPLICATE_EN (edge rows).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module line_buff_ctrl #(
    parameter int IMG_WIDTH  = 1600,
    parameter int IMG_HEIGHT = 1200,
    parameter int ADDR_W     = 11
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    line_buff_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_x_last = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [10:0]       c_y_last = 11'(IMG_HEIGHT - 1);

    function automatic logic [1:0] rot(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] d0,
                                        input logic [7:0] d1, input logic [7:0] d2);
        case (s)
            2'd0:    return d0;
            2'd1:    return d1;
            default: return d2;
        endcase
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_x;
    logic [10:0]       r_y;
    logic [1:0]        r_wr_sel;

    logic [ADDR_W-1:0] w_cur_x;
    logic [10:0]       w_cur_y;
    logic [1:0]        w_cur_sel;
    logic              w_accept;
    logic              w_eol;
    logic              w_last;
    logic              w_emit;
    logic [ADDR_W-1:0] w_x_nxt;
    logic [10:0]       w_y_nxt;
    logic [1:0]        w_sel_nxt;

    logic              r_p_valid;
    logic [1:0]        r_p_sel;
    logic              r_frame_done;
    logic [7:0]        r_out_bot;
    logic [ADDR_W-1:0] r_out_x;
    logic [10:0]       r_out_y;
    logic [7:0]        r_hold_top;
    logic [7:0]        r_hold_mid;
    logic [7:0]        w_top_rd;
    logic [7:0]        w_mid_rd;
`ifdef LINE_BUFF_CTRL_BORDER_REPLICATE_EN
    logic              r_p_row0;
    logic              r_p_row1;
`endif

    // in_sof overrides the position so the restarting pixel lands at (0,0) in buffer 0
    always_comb begin
        w_cur_x   = bus.in_sof ? '0    : r_x;
        w_cur_y   = bus.in_sof ? '0    : r_y;
        w_cur_sel = bus.in_sof ? 2'd0  : r_wr_sel;
        w_accept  = rst_n && bus.in_valid && (bus.in_sof || (r_state != ST_IDLE));
        w_eol     = (w_cur_x == c_x_last);
        w_last    = w_eol && (w_cur_y == c_y_last);
`ifdef LINE_BUFF_CTRL_BORDER_REPLICATE_EN
        w_emit    = w_accept;
`else
        w_emit    = w_accept && (w_cur_y >= 11'd2);
`endif
        bus.lb_addr  = w_cur_x;
        bus.lb_wdata = bus.in_data;
        bus.lb_we    = w_accept ? (3'b001 << w_cur_sel) : 3'b000;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_sel_nxt   = r_wr_sel;
        if (w_accept) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
                w_x_nxt     = '0;
                w_y_nxt     = '0;
                w_sel_nxt   = 2'd0;
            end else if (w_eol) begin
                w_x_nxt     = '0;
                w_y_nxt     = w_cur_y + 11'd1;
                w_sel_nxt   = rot(w_cur_sel);
                w_state_nxt = (w_cur_y >= 11'd1) ? ST_RUN : ST_FILL;
            end else begin
                w_x_nxt     = w_cur_x + 1'b1;
                w_y_nxt     = w_cur_y;
                w_sel_nxt   = w_cur_sel;
                w_state_nxt = bus.in_sof ? ST_FILL : r_state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_wr_sel     <= 2'd0;
            r_p_valid    <= 1'b0;
            r_p_sel      <= 2'd0;
            r_frame_done <= 1'b0;
            r_out_bot    <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_hold_top   <= '0;
            r_hold_mid   <= '0;
`ifdef LINE_BUFF_CTRL_BORDER_REPLICATE_EN
            r_p_row0     <= 1'b0;
            r_p_row1     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_wr_sel     <= w_sel_nxt;
            r_p_valid    <= w_emit;
            r_frame_done <= w_emit && w_last;
            if (w_emit) begin
                r_p_sel   <= w_cur_sel;
                r_out_bot <= bus.in_data;
                r_out_x   <= w_cur_x;
                r_out_y   <= w_cur_y;
`ifdef LINE_BUFF_CTRL_BORDER_REPLICATE_EN
                r_p_row0  <= (w_cur_y == 11'd0);
                r_p_row1  <= (w_cur_y == 11'd1);
`endif
            end
            // Read data is only valid for one cycle; keep a copy for the hold phase
            if (r_p_valid) begin
                r_hold_top <= w_top_rd;
                r_hold_mid <= w_mid_rd;
            end
        end
    end

    // Row y-1 sits in buffer (w+2)%3, row y-2 in buffer (w+1)%3
    always_comb begin
        w_mid_rd = pick(rot(rot(r_p_sel)), bus.lb_rdata0, bus.lb_rdata1, bus.lb_rdata2);
        w_top_rd = pick(rot(r_p_sel), bus.lb_rdata0, bus.lb_rdata1, bus.lb_rdata2);
`ifdef LINE_BUFF_CTRL_BORDER_REPLICATE_EN
        if (r_p_row0) begin
            w_mid_rd = r_out_bot;
            w_top_rd = r_out_bot;
        end else if (r_p_row1) begin
            w_top_rd = w_mid_rd;
        end
`endif
    end

    always_comb begin
        bus.out_valid  = r_p_valid;
        bus.out_top    = r_p_valid ? w_top_rd : r_hold_top;
        bus.out_mid    = r_p_valid ? w_mid_rd : r_hold_mid;
        bus.out_bot    = r_out_bot;
        bus.out_x      = r_out_x;
        bus.out_y      = r_out_y;
        bus.frame_done = r_frame_done;
    end

endmodule

`default_nettype wire

// File: tb/tb_line_buff_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_line_buff_ctrl                                               |
// | Brief    : Vector-table and scoreboard bench for line_buff_ctrl, 4x4 frame.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_line_buff_ctrl;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 2;

    typedef struct {
        logic          valid;
        logic          sof;
        logic [7:0]    data;
        logic [2:0]    exp_we;
        logic [AW-1:0] exp_addr;
        logic          emit;
        logic [7:0]    top;
        logic [7:0]    mid;
        logic [7:0]    bot;
        logic [AW-1:0] x;
        logic [10:0]   y;
        logic          done;
    } vec_t;

    typedef struct {
        logic [7:0]    top;
        logic [7:0]    mid;
        logic [7:0]    bot;
        logic [AW-1:0] x;
        logic [10:0]   y;
        logic          done;
    } col_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic hold_en = 1'b0;
    col_t sb[$];
    col_t last_col;
    col_t got;

    logic [7:0] mem0[4];
    logic [7:0] mem1[4];
    logic [7:0] mem2[4];

    line_buff_ctrl_if #(.ADDR_W(AW)) bus ();

    line_buff_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Read-first single-port line buffers with registered read data
    always @(posedge clk) begin
        bus.lb_rdata0 <= mem0[bus.lb_addr];
        bus.lb_rdata1 <= mem1[bus.lb_addr];
        bus.lb_rdata2 <= mem2[bus.lb_addr];
        if (bus.lb_we[0]) mem0[bus.lb_addr] <= bus.lb_wdata;
        if (bus.lb_we[1]) mem1[bus.lb_addr] <= bus.lb_wdata;
        if (bus.lb_we[2]) mem2[bus.lb_addr] <= bus.lb_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [7:0] pix(input int x, input int y);
        return 8'(16 * y + x);
    endfunction

    function automatic vec_t mk(input int x, input int y, input logic sof);
        vec_t v;
        v.valid    = 1'b1;
        v.sof      = sof;
        v.data     = pix(x, y);
        v.exp_we   = 3'(1 << (y % 3));
        v.exp_addr = AW'(x);
        v.x        = AW'(x);
        v.y        = 11'(y);
        v.done     = (x == W - 1) && (y == H - 1);
        v.bot      = pix(x, y);
`ifdef LINE_BUFF_CTRL_BORDER_REPLICATE_EN
        v.emit = 1'b1;
        if (y == 0) begin
            v.top = pix(x, 0);
            v.mid = pix(x, 0);
        end else if (y == 1) begin
            v.top = pix(x, 0);
            v.mid = pix(x, 0);
        end else begin
            v.top = pix(x, y - 2);
            v.mid = pix(x, y - 1);
        end
`else
        v.emit = (y >= 2);
        v.top  = (y >= 2) ? pix(x, y - 2) : 8'h00;
        v.mid  = (y >= 1) ? pix(x, y - 1) : 8'h00;
`endif
        return v;
    endfunction

    function automatic vec_t mk_idle(input logic valid);
        vec_t v;
        v = mk(0, 0, 1'b0);
        v.valid  = valid;
        v.exp_we = 3'b000;
        v.emit   = 1'b0;
        v.data   = 8'h5A;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        col_t c;
        @(negedge clk);
        bus.in_valid = v.valid;
        bus.in_sof   = v.sof;
        bus.in_data  = v.data;
        #1;
        check("lb_we", 32'(bus.lb_we), 32'(v.exp_we));
        if (v.exp_we != 3'b000) begin
            check("lb_addr", 32'(bus.lb_addr), 32'(v.exp_addr));
            check("lb_wdata", 32'(bus.lb_wdata), 32'(v.data));
        end
        if (v.valid && v.emit) begin
            c.top = v.top; c.mid = v.mid; c.bot = v.bot;
            c.x = v.x; c.y = v.y; c.done = v.done;
            sb.push_back(c);
        end
    endtask

    task automatic frame(input int npix, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            apply(mk(i % W, i / W, i == 0));
            if (gaps) apply(mk_idle(1'b0));
        end
    endtask

    // Scoreboard consumer
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    got = sb.pop_front();
                    check("out_top", 32'(bus.out_top), 32'(got.top));
                    check("out_mid", 32'(bus.out_mid), 32'(got.mid));
                    check("out_bot", 32'(bus.out_bot), 32'(got.bot));
                    check("out_x", 32'(bus.out_x), 32'(got.x));
                    check("out_y", 32'(bus.out_y), 32'(got.y));
                    check("frame_done", 32'(bus.frame_done), 32'(got.done));
                    last_col = got;
                end
            end else begin
                if (bus.frame_done) check("frame_done_no_valid", 32'(bus.frame_done), 32'd0);
                if (hold_en) begin
                    check("hold_top", 32'(bus.out_top), 32'(last_col.top));
                    check("hold_bot", 32'(bus.out_bot), 32'(last_col.bot));
                    check("hold_x", 32'(bus.out_x), 32'(last_col.x));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

    vec_t tbl[2*W*H];

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem0[i] = 8'hEE; mem1[i] = 8'hEE; mem2[i] = 8'hEE;
        end
        // Two back-to-back frames, second in_sof right after the last pixel
        for (int i = 0; i < 2 * W * H; i++)
            tbl[i] = mk((i % (W * H)) % W, (i % (W * H)) / W, (i % (W * H)) == 0);

        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b1;
        bus.in_data  = 8'h77;
        rst_n = 1'b0;
        #1;
        check("we_in_reset", 32'(bus.lb_we), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_out_top", 32'(bus.out_top), 32'd0);
        check("rst_out_mid", 32'(bus.out_mid), 32'd0);
        check("rst_out_bot", 32'(bus.out_bot), 32'd0);
        check("rst_out_x", 32'(bus.out_x), 32'd0);
        check("rst_out_y", 32'(bus.out_y), 32'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;

        // Pixels without in_sof while idle are ignored
        for (int i = 0; i < 3; i++) apply(mk_idle(1'b1));

        for (int i = 0; i < 2 * W * H; i++) apply(tbl[i]);
        apply(mk_idle(1'b0));
        apply(mk_idle(1'b0));

        // Gapped stream: identical columns, outputs hold through gaps
        hold_en = 1'b1;
        frame(W * H, 1'b1);
        apply(mk_idle(1'b0));
        hold_en = 1'b0;

        // Abort at (x=2,y=2) by in_sof, then a full new frame
        frame(2 * W + 2, 1'b0);
        frame(W * H, 1'b0);
        apply(mk_idle(1'b0));
        apply(mk_idle(1'b0));

        // Reset in the middle of row 2
        frame(2 * W + 2, 1'b0);
        apply(mk_idle(1'b0));
        apply(mk_idle(1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b1;
        #1;
        check("we_mid_reset", 32'(bus.lb_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_out_top", 32'(bus.out_top), 32'd0);
        check("mrst_out_mid", 32'(bus.out_mid), 32'd0);
        check("mrst_out_bot", 32'(bus.out_bot), 32'd0);
        check("mrst_out_x", 32'(bus.out_x), 32'd0);
        check("mrst_out_y", 32'(bus.out_y), 32'd0);
        for (int i = 0; i < 3; i++) apply(mk_idle(1'b1));
        frame(W * H, 1'b0);

        repeat (3) apply(mk_idle(1'b0));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
